// File: rtl/clock_pkg.sv
// Shared definitions for the clock design: rx parser state encodings, frame
// header bytes, error codes and the calendar helper used for day checks.
package clock_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_T_MONTH = 3'b001,
    S_T_DAY   = 3'b010,
    S_T_HOUR  = 3'b011,
    S_T_MIN   = 3'b100,
    S_T_SEC   = 3'b101,
    S_A_HOUR  = 3'b110,
    S_A_MIN   = 3'b111
  } rx_state_e;

  localparam logic [7:0] HDR_TIME  = 8'hAA;
  localparam logic [7:0] HDR_ALARM = 8'hBB;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_RANGE   = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_code_e;

  typedef struct packed {
    logic [3:0] month;
    logic [4:0] day;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
  } time_t;

  // Staging holds every field except seconds, which commit straight from the last byte.
  typedef struct packed {
    logic [3:0] month;
    logic [4:0] day;
    logic [4:0] hour;
    logic [5:0] min;
  } stage_t;

  // February always admits the 29th; the parser has no notion of year.
  function automatic logic [4:0] days_in_month(input logic [3:0] month);
    case (month)
      4'd2:                      return 5'd29;
      4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
      default:                   return 5'd31;
    endcase
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Inter-byte watchdog: reloads on clear, counts down while run is high and
// flags expired for one cycle when the terminal count is reached.
module frame_timer #(
  parameter int unsigned CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LOAD = W'(CYCLES - 1);

  // Holds cycles remaining, so the reload value corresponds to zero elapsed.
  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    cnt_d   = cnt_q;
    expired = 1'b0;
    if (clear) begin
      cnt_d = LOAD;
    end else if (run) begin
      if (cnt_q == '0) expired = 1'b1;
      else             cnt_d   = cnt_q - W'(1);
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= LOAD;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Decodes time-set (AA mm dd hh mi ss) and alarm-set (BB hh mi) frames from the
// UART byte stream, range-checks each field and emits registered commit pulses.
module uart_cmd_parser
  import clock_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned TIMEOUT_MS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       time_load,
  output logic [3:0] month,
  output logic [4:0] day,
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       alarm_load,
  output logic [4:0] alarm_hour,
  output logic [5:0] alarm_min,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int unsigned TIMEOUT_CYCLES = CLK_FREQ / 1000 * TIMEOUT_MS;

  rx_state_e  state_q, state_d;
  stage_t     stg_q, stg_d;
  time_t      time_q, time_d;
  logic [4:0] alarm_hour_q, alarm_hour_d;
  logic [5:0] alarm_min_q, alarm_min_d;
  logic       time_load_q, time_load_d;
  logic       alarm_load_q, alarm_load_d;
  logic       frame_err_q, frame_err_d;
  err_code_e  err_code_q, err_code_d;
  logic       field_ok;
  logic       expired;

  frame_timer #(.CYCLES(TIMEOUT_CYCLES)) u_frame_timer (
    .clk     (clk),
    .rst_n   (rst),
    .clear   (rx_valid),
    .run     (state_q != S_IDLE),
    .expired (expired)
  );

  // Range check on the full byte, before truncation to the field width.
  always_comb begin
    field_ok = 1'b0;
    case (state_q)
      S_T_MONTH:           field_ok = (rx_data >= 8'd1) && (rx_data <= 8'd12);
      S_T_DAY:             field_ok = (rx_data >= 8'd1) &&
                                      (rx_data <= {3'b000, days_in_month(stg_q.month)});
      S_T_HOUR, S_A_HOUR:  field_ok = (rx_data <= 8'd23);
      S_T_MIN, S_T_SEC,
      S_A_MIN:             field_ok = (rx_data <= 8'd59);
      default:             field_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    stg_d        = stg_q;
    time_d       = time_q;
    alarm_hour_d = alarm_hour_q;
    alarm_min_d  = alarm_min_q;
    time_load_d  = 1'b0;
    alarm_load_d = 1'b0;
    frame_err_d  = 1'b0;
    err_code_d   = err_code_q;

    if (rx_valid) begin
      if (state_q == S_IDLE) begin
        if (rx_data == HDR_TIME)       state_d = S_T_MONTH;
        else if (rx_data == HDR_ALARM) state_d = S_A_HOUR;
      end else if (field_ok) begin
        case (state_q)
          S_T_MONTH: begin stg_d.month = rx_data[3:0]; state_d = S_T_DAY;  end
          S_T_DAY:   begin stg_d.day   = rx_data[4:0]; state_d = S_T_HOUR; end
          S_T_HOUR:  begin stg_d.hour  = rx_data[4:0]; state_d = S_T_MIN;  end
          S_T_MIN:   begin stg_d.min   = rx_data[5:0]; state_d = S_T_SEC;  end
          S_T_SEC: begin
            time_d      = '{month: stg_q.month, day: stg_q.day, hour: stg_q.hour,
                            min: stg_q.min, sec: rx_data[5:0]};
            time_load_d = 1'b1;
            state_d     = S_IDLE;
          end
          S_A_HOUR:  begin stg_d.hour  = rx_data[4:0]; state_d = S_A_MIN;  end
          S_A_MIN: begin
            alarm_hour_d = stg_q.hour;
            alarm_min_d  = rx_data[5:0];
            alarm_load_d = 1'b1;
            state_d      = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end else begin
        // A header byte can never pass a field check, so treat it as the start of a new frame.
        frame_err_d = 1'b1;
        err_code_d  = ERR_RANGE;
        if (rx_data == HDR_TIME)       state_d = S_T_MONTH;
        else if (rx_data == HDR_ALARM) state_d = S_A_HOUR;
        else                           state_d = S_IDLE;
      end
    end else if (expired) begin
      state_d     = S_IDLE;
      frame_err_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      stg_q        <= '0;
      time_q       <= '0;
      alarm_hour_q <= '0;
      alarm_min_q  <= '0;
      time_load_q  <= 1'b0;
      alarm_load_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      stg_q        <= stg_d;
      time_q       <= time_d;
      alarm_hour_q <= alarm_hour_d;
      alarm_min_q  <= alarm_min_d;
      time_load_q  <= time_load_d;
      alarm_load_q <= alarm_load_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign time_load  = time_load_q;
  assign month      = time_q.month;
  assign day        = time_q.day;
  assign hour       = time_q.hour;
  assign min        = time_q.min;
  assign sec        = time_q.sec;
  assign alarm_load = alarm_load_q;
  assign alarm_hour = alarm_hour_q;
  assign alarm_min  = alarm_min_q;
  assign frame_err  = frame_err_q;
  assign err_code   = err_code_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: good frames, range errors, resync,
// timeout at and around expiry, and reset mid-frame.
module tb_uart_cmd_parser;

  localparam int unsigned CLK_FREQ   = 1_000_000;
  localparam int unsigned TIMEOUT_MS = 1;
  localparam int          TC         = CLK_FREQ / 1000 * TIMEOUT_MS;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       time_load;
  logic [3:0] month;
  logic [4:0] day;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic       alarm_load;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int n_time = 0;
  int n_alarm = 0;
  int n_err = 0;
  int snap_time, snap_alarm, snap_err;

  uart_cmd_parser #(.CLK_FREQ(CLK_FREQ), .TIMEOUT_MS(TIMEOUT_MS)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .time_load  (time_load),
    .month      (month),
    .day        (day),
    .hour       (hour),
    .min        (min),
    .sec        (sec),
    .alarm_load (alarm_load),
    .alarm_hour (alarm_hour),
    .alarm_min  (alarm_min),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (time_load)  n_time  <= n_time + 1;
    if (alarm_load) n_alarm <= n_alarm + 1;
    if (frame_err)  n_err   <= n_err + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Byte is captured on the next edge; returns 1 time unit after that edge.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic tx(input logic [7:0] b);
    @(posedge clk);
    #1;
    send(b);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    check("reset_outputs",
          {time_load, month, day, hour, min, sec, alarm_load, alarm_hour,
           alarm_min, frame_err, err_code, busy}, 64'd0);
    rst = 1'b1;
    idle(2);

    // Good time frame, one byte per cycle.
    send(8'hAA);
    check("busy_after_hdr", busy, 1'b1);
    send(8'h03); send(8'h1F); send(8'h17); send(8'h3B); send(8'h3B);
    check("t1_load", time_load, 1'b1);
    check("t1_fields", {month, day, hour, min, sec}, {4'd3, 5'd31, 5'd23, 6'd59, 6'd59});
    check("t1_busy_fall", busy, 1'b0);
    idle(1);
    check("t1_pulse_width", time_load, 1'b0);
    check("t1_no_err", n_err, 0);

    // April 31 rejected, outputs held.
    tx(8'hAA); tx(8'h04); tx(8'h1F);
    check("apr31_err", frame_err, 1'b1);
    check("apr31_code", err_code, 2'b01);
    check("apr31_idle", busy, 1'b0);
    check("apr31_hold", {month, day, hour, min, sec}, {4'd3, 5'd31, 5'd23, 6'd59, 6'd59});
    idle(1);
    check("err_pulse_width", frame_err, 1'b0);
    check("err_code_holds", err_code, 2'b01);

    // Feb 29 accepted.
    tx(8'hAA); tx(8'h02); tx(8'h1D); tx(8'h00); tx(8'h00); tx(8'h00);
    check("feb29_load", time_load, 1'b1);
    check("feb29_fields", {month, day, hour, min, sec}, {4'd2, 5'd29, 5'd0, 6'd0, 6'd0});

    // Field boundary rejections.
    tx(8'hAA); tx(8'h02); tx(8'h1E);
    check("feb30_err", frame_err, 1'b1);
    tx(8'hAA); tx(8'h00);
    check("month0_err", frame_err, 1'b1);
    tx(8'hAA); tx(8'h0D);
    check("month13_err", frame_err, 1'b1);
    tx(8'hAA); tx(8'h01); tx(8'h00);
    check("day0_err", frame_err, 1'b1);
    tx(8'hBB); tx(8'h18);
    check("hour24_err", frame_err, 1'b1);
    tx(8'hBB); tx(8'h00); tx(8'h3C);
    check("min60_err", {frame_err, busy}, 2'b10);
    check("range_hold", {month, day, alarm_hour, alarm_min}, {4'd2, 5'd29, 5'd0, 6'd0});

    // Header inside an alarm frame resyncs into a time frame.
    tx(8'hBB); tx(8'h07);
    snap_alarm = n_alarm;
    tx(8'hAA);
    check("resync_err", {frame_err, err_code, busy}, {1'b1, 2'b01, 1'b1});
    tx(8'h01); tx(8'h01); tx(8'h00); tx(8'h00); tx(8'h00);
    check("resync_load", time_load, 1'b1);
    check("resync_fields", {month, day, hour, min, sec}, {4'd1, 5'd1, 5'd0, 6'd0, 6'd0});
    idle(1);
    check("resync_no_alarm", n_alarm, snap_alarm);

    // Timeout after the last byte of a stalled alarm frame.
    tx(8'hBB); tx(8'h06);
    idle(TC - 1);
    check("to_not_early", {frame_err, busy}, 2'b01);
    idle(1);
    check("to_err", {frame_err, err_code, busy}, {1'b1, 2'b10, 1'b0});
    snap_err = n_err + 1;
    tx(8'h1E);
    check("orphan_ignored", {frame_err, alarm_load, busy}, 3'b000);
    idle(1);
    check("orphan_no_err", n_err, snap_err);

    // Byte arriving in the expiry cycle wins.
    tx(8'hBB);
    idle(TC - 1);
    send(8'h05);
    check("expiry_byte_wins", {frame_err, busy}, 2'b01);
    idle(1);
    check("expiry_no_late_err", frame_err, 1'b0);
    tx(8'h0A);
    check("expiry_alarm_load", alarm_load, 1'b1);
    check("expiry_alarm_fields", {alarm_hour, alarm_min}, {5'd5, 6'd10});

    // Alarm frame.
    tx(8'hBB); tx(8'h06); tx(8'h1E);
    check("alarm_load", alarm_load, 1'b1);
    check("alarm_fields", {alarm_hour, alarm_min}, {5'd6, 6'd30});
    check("alarm_no_time", time_load, 1'b0);
    idle(1);
    check("alarm_pulse_width", alarm_load, 1'b0);

    // Reset mid-frame discards it.
    tx(8'hAA); tx(8'h05);
    rst = 1'b0;
    #1;
    check("midrst_outputs",
          {time_load, month, day, hour, min, sec, alarm_load, alarm_hour,
           alarm_min, frame_err, err_code, busy}, 64'd0);
    idle(2);
    rst = 1'b1;
    snap_time  = n_time;
    snap_alarm = n_alarm;
    snap_err   = n_err;
    tx(8'h1F);
    idle(20);
    check("midrst_no_pulse", {n_time == snap_time, n_alarm == snap_alarm, n_err == snap_err}, 3'b111);
    check("midrst_idle", {busy, month, day}, 10'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
